// File: rtl/diag_ebus_reader.sv
// diag_ebus_reader
// Diagnostic-side EBUS read initiator. Runs a sequence of DIAG_FUNC read
// codes. For each code it raises the read strobe, waits SETTLE cycles for the
// bus to settle, then samples the 36-bit EBUS word. It checks that exactly
// one board drove the bus and hands the word to the consumer over a
// valid/ready handshake.
//
// Ports:
//   eboxClk, RESET_n      clock, async active-low reset
//   start                 begin a run (IDLE only)
//   firstFunc, count      first function code, number of reads minus 1
//   CRAM_DIAG_FUNC        function code presented to the boards
//   DIAG_READ_FUNC_13X    read strobe to the boards
//   EBUS, drivingEBUS     bus data and per-board drive indications
//   rdData, rdFunc        captured word and the code that produced it
//   rdValid, rdReady      output handshake
//   busy, done            run in progress / one-cycle end-of-run pulse
//   errNoDrv, errMulti    sticky driver-count faults, cleared on start
module diag_ebus_reader #(
   parameter int unsigned SETTLE = 3,
   parameter int unsigned NDRV   = 8
) (
   input  logic            eboxClk,
   input  logic            RESET_n,
   input  logic            start,
   input  logic [8:0]      firstFunc,
   input  logic [2:0]      count,
   output logic [8:0]      CRAM_DIAG_FUNC,
   output logic            DIAG_READ_FUNC_13X,
   input  logic [0:35]     EBUS,
   input  logic [NDRV-1:0] drivingEBUS,
   output logic [0:35]     rdData,
   output logic [8:0]      rdFunc,
   output logic            rdValid,
   input  logic            rdReady,
   output logic            busy,
   output logic            done,
   output logic            errNoDrv,
   output logic            errMulti
);

   localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

   typedef enum logic [2:0] {StIdle, StDrive, StSample, StHold, StDone} state_e;

   state_e     state_q;
   logic [8:0] func_q;
   logic [2:0] remaining_q;
   logic [3:0] settle_q;

   logic drv_none;
   logic drv_multi;

   // x & (x-1) is nonzero exactly when more than one bit is set.
   assign drv_none  = (drivingEBUS == '0);
   assign drv_multi = ((drivingEBUS & (drivingEBUS - NDRV'(1))) != '0);

   always_ff @(posedge eboxClk or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q            <= StIdle;
         func_q             <= '0;
         remaining_q        <= '0;
         settle_q           <= '0;
         CRAM_DIAG_FUNC     <= '0;
         DIAG_READ_FUNC_13X <= 1'b0;
         rdData             <= '0;
         rdFunc             <= '0;
         rdValid            <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         errNoDrv           <= 1'b0;
         errMulti           <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  func_q             <= firstFunc;
                  remaining_q        <= count;
                  errNoDrv           <= 1'b0;
                  errMulti           <= 1'b0;
                  busy               <= 1'b1;
                  CRAM_DIAG_FUNC     <= firstFunc;
                  DIAG_READ_FUNC_13X <= 1'b1;
                  settle_q           <= SettleLoad;
                  state_q            <= StDrive;
               end
            end
            StDrive: begin
               if (settle_q == 4'd0) begin
                  state_q <= StSample;
               end else begin
                  settle_q <= settle_q - 4'd1;
               end
            end
            StSample: begin
               rdFunc             <= func_q;
               rdValid            <= 1'b1;
               DIAG_READ_FUNC_13X <= 1'b0;
               state_q            <= StHold;
               // An undriven bus floats; return a clean zero instead.
               if (drv_none) begin
                  rdData   <= '0;
                  errNoDrv <= 1'b1;
               end else begin
                  rdData <= EBUS;
               end
               if (drv_multi) begin
                  errMulti <= 1'b1;
               end
            end
            StHold: begin
               if (rdValid && rdReady) begin
                  rdValid <= 1'b0;
                  if (remaining_q == 3'd0) begin
                     done           <= 1'b1;
                     busy           <= 1'b0;
                     CRAM_DIAG_FUNC <= '0;
                     state_q        <= StDone;
                  end else begin
                     remaining_q        <= remaining_q - 3'd1;
                     func_q             <= func_q + 9'd1;
                     CRAM_DIAG_FUNC     <= func_q + 9'd1;
                     DIAG_READ_FUNC_13X <= 1'b1;
                     settle_q           <= SettleLoad;
                     state_q            <= StDrive;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diag_ebus_reader.sv
// Self-checking bench for diag_ebus_reader: a table of read runs, each with a
// scoreboard of expected words, plus hand-written reset sequences.
module tb_diag_ebus_reader;

   localparam int unsigned SETTLE = 3;
   localparam int unsigned NDRV   = 8;

   logic            eboxClk = 1'b0;
   logic            RESET_n;
   logic            start;
   logic [8:0]      firstFunc;
   logic [2:0]      count;
   logic [8:0]      CRAM_DIAG_FUNC;
   logic            DIAG_READ_FUNC_13X;
   logic [35:0]     EBUS;
   logic [NDRV-1:0] drivingEBUS;
   logic [35:0]     rdData;
   logic [8:0]      rdFunc;
   logic            rdValid;
   logic            rdReady;
   logic            busy;
   logic            done;
   logic            errNoDrv;
   logic            errMulti;

   diag_ebus_reader #(
      .SETTLE(SETTLE),
      .NDRV  (NDRV)
   ) dut (
      .eboxClk           (eboxClk),
      .RESET_n           (RESET_n),
      .start             (start),
      .firstFunc         (firstFunc),
      .count             (count),
      .CRAM_DIAG_FUNC    (CRAM_DIAG_FUNC),
      .DIAG_READ_FUNC_13X(DIAG_READ_FUNC_13X),
      .EBUS              (EBUS),
      .drivingEBUS       (drivingEBUS),
      .rdData            (rdData),
      .rdFunc            (rdFunc),
      .rdValid           (rdValid),
      .rdReady           (rdReady),
      .busy              (busy),
      .done              (done),
      .errNoDrv          (errNoDrv),
      .errMulti          (errMulti)
   );

   always #5 eboxClk = ~eboxClk;

   typedef struct {
      logic [8:0]  first_func;
      logic [2:0]  cnt;
      logic [35:0] ebus;
      bit          func_dep;  // low 9 bits of EBUS follow the presented code
      logic [7:0]  drv0;      // drive pattern for read 0
      logic [7:0]  drv1;      // drive pattern for read 1
      logic [7:0]  drv_rest;  // drive pattern for later reads
      int          stall;     // cycles rdReady is held low on the first word
      bit          sw_busy;   // pulse start again while the run is busy
   } vec_t;

   typedef struct {
      logic [8:0]  func;
      logic [35:0] data;
   } exp_t;

   vec_t vecs[5];
   vec_t cur;
   exp_t sb[$];

   int n_check = 0;
   int n_fail  = 0;
   int acc;           // words accepted in the current run
   int stall_cnt;
   int strobe_len;
   int done_cnt = 0;
   bit expect_drive;

   assign drivingEBUS = (acc == 0) ? cur.drv0 : ((acc == 1) ? cur.drv1 : cur.drv_rest);
   assign EBUS        = cur.func_dep ? {cur.ebus[35:9], CRAM_DIAG_FUNC} : cur.ebus;

   function automatic void check(input string name, input logic [63:0] got,
                                 input logic [63:0] exp);
      n_check++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endfunction

   function automatic logic [7:0] pick(input vec_t v, input int i);
      return (i == 0) ? v.drv0 : ((i == 1) ? v.drv1 : v.drv_rest);
   endfunction

   task automatic push_expect(input vec_t v, output bit nodrv, output bit multi);
      exp_t e;
      logic [7:0] d;
      nodrv = 1'b0;
      multi = 1'b0;
      sb.delete();
      for (int i = 0; i <= int'(v.cnt); i++) begin
         e.func = v.first_func + 9'(i);
         d      = pick(v, i);
         if (d == 8'h00) begin
            e.data = '0;
            nodrv  = 1'b1;
         end else begin
            e.data = v.func_dep ? {v.ebus[35:9], e.func} : v.ebus;
         end
         if ($countones(d) > 1) multi = 1'b1;
         sb.push_back(e);
      end
   endtask

   // One clock of monitoring, evaluated on the falling edge.
   task automatic step();
      @(negedge eboxClk);
      if (done) begin
         done_cnt++;
         check("done_after_last_word", 64'(sb.size()), 64'd0);
      end
      if (DIAG_READ_FUNC_13X) begin
         if (strobe_len == 0 && sb.size() != 0) begin
            check("drive_func", 64'(CRAM_DIAG_FUNC), 64'(sb[0].func));
         end
         strobe_len++;
      end else if (strobe_len != 0) begin
         check("strobe_len", 64'(strobe_len), 64'(SETTLE + 1));
         check("valid_after_sample", 64'(rdValid), 64'd1);
         strobe_len = 0;
      end
      if (expect_drive) begin
         check("drive_next_cycle", 64'(DIAG_READ_FUNC_13X), 64'd1);
         check("valid_cleared", 64'(rdValid), 64'd0);
         expect_drive = 1'b0;
      end
      if (rdValid) begin
         if (sb.size() == 0) begin
            n_check++;
            n_fail++;
            $display("FAIL unexpected_word: got func 0x%0h, expected no word", rdFunc);
            rdReady = 1'b1;
         end else begin
            check("rd_data", 64'(rdData), 64'(sb[0].data));
            check("rd_func", 64'(rdFunc), 64'(sb[0].func));
            check("hold_strobe", 64'(DIAG_READ_FUNC_13X), 64'd0);
            check("hold_cram", 64'(CRAM_DIAG_FUNC), 64'(sb[0].func));
            if (acc == 0 && stall_cnt < cur.stall) begin
               rdReady = 1'b0;
               stall_cnt++;
            end else begin
               rdReady = 1'b1;
            end
            if (rdReady) begin
               void'(sb.pop_front());
               acc++;
               expect_drive = (acc <= int'(cur.cnt));
            end
         end
      end else begin
         rdReady = 1'b1;
      end
   endtask

   task automatic kick(input vec_t v, output bit nodrv, output bit multi);
      cur          = v;
      acc          = 0;
      stall_cnt    = 0;
      strobe_len   = 0;
      expect_drive = 1'b0;
      push_expect(v, nodrv, multi);
      firstFunc = v.first_func;
      count     = v.cnt;
      start     = 1'b1;
      step();
      start     = 1'b0;
      firstFunc = ~v.first_func;  // must have been latched
      count     = ~v.cnt;
      check("busy_on", 64'(busy), 64'd1);
      check("err_nodrv_cleared", 64'(errNoDrv), 64'd0);
      check("err_multi_cleared", 64'(errMulti), 64'd0);
   endtask

   task automatic run_vec(input vec_t v);
      bit exp_nodrv;
      bit exp_multi;
      int d0;
      d0 = done_cnt;
      kick(v, exp_nodrv, exp_multi);
      if (v.sw_busy) begin
         step();
         step();
         firstFunc = 9'o000;
         count     = 3'd7;
         start     = 1'b1;
         step();
         start     = 1'b0;
      end
      for (int c = 0; c < 400 && done_cnt == d0; c++) step();
      check("done_seen", 64'(done_cnt - d0), 64'd1);
      step();
      check("done_one_cycle", 64'(done), 64'd0);
      check("words_left", 64'(sb.size()), 64'd0);
      check("err_nodrv_end", 64'(errNoDrv), 64'(exp_nodrv));
      check("err_multi_end", 64'(errMulti), 64'(exp_multi));
      check("busy_end", 64'(busy), 64'd0);
      check("cram_end", 64'(CRAM_DIAG_FUNC), 64'd0);
      check("strobe_end", 64'(DIAG_READ_FUNC_13X), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cram"}, 64'(CRAM_DIAG_FUNC), 64'd0);
      check({tag, "_strobe"}, 64'(DIAG_READ_FUNC_13X), 64'd0);
      check({tag, "_rddata"}, 64'(rdData), 64'd0);
      check({tag, "_rdfunc"}, 64'(rdFunc), 64'd0);
      check({tag, "_rdvalid"}, 64'(rdValid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_errnodrv"}, 64'(errNoDrv), 64'd0);
      check({tag, "_errmulti"}, 64'(errMulti), 64'd0);
   endtask

   initial begin
      bit nd;
      bit mu;
      bit reached;
      int d0;

      //          first    cnt   ebus              dep   drv0   drv1   rest   stall busy
      vecs[0] = '{9'o130, 3'd0, 36'o123456701234, 1'b0, 8'h01, 8'h01, 8'h01, 0,  1'b0};
      vecs[1] = '{9'o130, 3'd7, 36'o707070707000, 1'b1, 8'h01, 8'h80, 8'h04, 0,  1'b1};
      vecs[2] = '{9'o200, 3'd1, 36'o555555555000, 1'b1, 8'h01, 8'h01, 8'h01, 10, 1'b0};
      vecs[3] = '{9'o300, 3'd2, 36'o111122223333, 1'b0, 8'h00, 8'h03, 8'h10, 0,  1'b0};
      vecs[4] = '{9'o776, 3'd2, 36'o246024602000, 1'b1, 8'h02, 8'h02, 8'h02, 0,  1'b0};

      cur          = vecs[0];
      acc          = 0;
      stall_cnt    = 0;
      strobe_len   = 0;
      expect_drive = 1'b0;
      RESET_n      = 1'b0;
      start        = 1'b0;
      firstFunc    = '0;
      count        = '0;
      rdReady      = 1'b1;

      #3;
      check_all_zero("reset");
      step();
      step();
      RESET_n = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset during DRIVE of read 2 after a multi-driver first read.
      d0 = done_cnt;
      kick('{9'o100, 3'd3, 36'o765432107654, 1'b0, 8'h03, 8'h01, 8'h01, 0, 1'b0}, nd, mu);
      reached = 1'b0;
      for (int c = 0; c < 100 && !reached; c++) begin
         step();
         reached = (acc == 1) && DIAG_READ_FUNC_13X;
      end
      check("reach_read2_drive", 64'(reached), 64'd1);
      check("multi_before_reset", 64'(errMulti), 64'd1);
      #2;
      RESET_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      sb.delete();
      strobe_len   = 0;
      expect_drive = 1'b0;
      step();
      step();
      step();
      RESET_n = 1'b1;
      step();
      check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
      check("idle_after_reset", 64'(busy), 64'd0);
      run_vec(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
      $finish;
   end

endmodule

// File: doc/diag_ebus_reader.md
Name: diag_ebus_reader

Overview:
- Diagnostic-side initiator for EBUS diagnostic reads: issues a run of DIAG_FUNC read codes, asserts the read strobe, waits for the bus to settle and captures the 36-bit EBUS word from whichever board drives it (SCD and peers).
- Checks for exactly one driver per read, then hands each captured word to the console/debug logic over a valid/ready handshake.
- Sits between the console command path and the EBUS mux.

Parameters:
- SETTLE, 3, eboxClk cycles between strobe assertion and EBUS sample (1..15).
- NDRV, 8, number of board "drivingEBUS" indications monitored.

Ports:
- eboxClk  in  1  EBOX clock; all state changes on rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a read run; sampled only in IDLE.
- firstFunc  in  9  first DIAG_FUNC code of the run, e.g. 9'o130.
- count  in  3  number of reads minus 1 (0 means 1 read, 7 means 8 reads).
- CRAM_DIAG_FUNC  out  9  function code currently presented to boards.
- DIAG_READ_FUNC_13X  out  1  read strobe to boards.
- EBUS  in  36  bus data [0:35].
- drivingEBUS  in  NDRV  per-board drive indication, e.g. SCDdrivingEBUS.
- rdData  out  36  captured word.
- rdFunc  out  9  function code that produced rdData.
- rdValid  out  1  rdData/rdFunc valid.
- rdReady  in  1  consumer accepts the word.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- errNoDrv  out  1  sticky: a sample saw zero drivers.
- errMulti  out  1  sticky: a sample saw more than one driver.

Behaviour:
- Reset (async, while RESET_n is low) clears every output to 0, the state to IDLE and all counters to 0. Reset mid-run abandons the run silently and no done pulse is produced.
- IDLE: busy=0 and DIAG_READ_FUNC_13X=0. When start=1, latch firstFunc into funcReg and count into remaining, clear errNoDrv/errMulti, then go to DRIVE. busy=1 from the next cycle.
- DRIVE:
  - CRAM_DIAG_FUNC=funcReg and DIAG_READ_FUNC_13X=1.
  - The settle counter loads SETTLE-1 on entry and decrements each cycle; at 0, go to SAMPLE.
  - The strobe is therefore high for exactly SETTLE cycles before the sample edge.
- SAMPLE (1 cycle, strobe still 1):
  - Capture rdData<=EBUS and rdFunc<=funcReg.
  - Popcount drivingEBUS: 0 sets errNoDrv and captures rdData=0; 2 or more sets errMulti and captures EBUS as-is.
  - Set rdValid=1, drop the strobe, go to HOLD.
- HOLD:
  - CRAM_DIAG_FUNC holds its value and the strobe stays 0.
  - When rdValid and rdReady are both 1, the transfer occurs on that edge and rdValid clears.
  - If remaining=0, go to DONE. Otherwise decrement remaining, increment funcReg modulo 512 (9'o777 wraps to 9'o000), and go to DRIVE.
  - rdReady while rdValid=0 is ignored.
  - rdValid, rdData and rdFunc stay stable until accepted.
- DONE: pulse done=1 for 1 cycle, clear busy, and go to IDLE. CRAM_DIAG_FUNC returns to 0. A start asserted during DONE is ignored.
- start while busy is ignored.
- Latency per word: SETTLE + 1 cycles from entering DRIVE to rdValid, with no wait cycles when rdReady is held at 1.
- Error flags stay set after the run until the next start or reset.

Test Plan:
- Single read: SETTLE=3, firstFunc=9'o130, count=0, drivingEBUS=8'b00000001, EBUS=36'o123456701234, rdReady=1.
  -> Strobe high exactly 4 cycles (3 DRIVE + 1 SAMPLE).
  -> rdValid 1 cycle with rdData=36'o123456701234 and rdFunc=9'o130.
  -> done pulses, errors stay 0.
- Burst of 8: count=7 and EBUS driven as function-dependent data.
  -> 8 words with rdFunc 9'o130..9'o137 in order, then done after the last acceptance.
- Backpressure: rdReady held low 10 cycles after the first rdValid.
  -> rdValid and rdData stay stable, the strobe stays 0 and CRAM_DIAG_FUNC holds.
  -> On rdReady=1 the next DRIVE starts the following cycle.
- Driver faults: drivingEBUS=0 on read 1 and 8'b00000011 on read 2.
  -> Read 1 gives rdData=0 and errNoDrv=1; errMulti=1 after read 2.
  -> Both flags persist until the next start.
- Wrap: firstFunc=9'o776, count=2 -> rdFunc 9'o776, 9'o777, 9'o000.
- Reset mid-run: RESET_n low during DRIVE of read 2.
  -> All outputs 0 immediately (async), no done pulse, and the next start works normally.
